// File: rtl/bin_pixel_feeder_pkg.sv
// Shared definitions for the binarized-pixel feeder: VGA 640x480 timing constants,
// default FIFO word width, pixel colour convention and FSM state encoding.
package bin_pixel_feeder_pkg;

    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_ACT   = 640;
    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_ACT   = 480;
    localparam int unsigned V_TOTAL = 525;

    localparam int unsigned DEFAULT_WORD_W = 16;

    typedef enum logic {
        PIX_WHITE = 1'b0,
        PIX_BLACK = 1'b1
    } pix_colour_e;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/bin_word_buf.sv
// Two-entry word buffer (cur/nxt) with same-cycle shift and capture, plus occupancy count.
module bin_word_buf import bin_pixel_feeder_pkg::*; #(
    parameter int unsigned WORD_W = DEFAULT_WORD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic              i_capture,
    input  logic [WORD_W-1:0] i_data,
    output logic [WORD_W-1:0] o_cur_word,
    output logic              o_cur_vld,
    output logic [1:0]        o_occ
);

    logic [WORD_W-1:0] r_cur_word;
    logic              r_cur_vld;
    logic [WORD_W-1:0] r_nxt_word;
    logic              r_nxt_vld;

    logic [WORD_W-1:0] w_cur_word_post;
    logic              w_cur_vld_post;
    logic              w_nxt_vld_post;

    // Capture decisions are made against the buffer as it looks after this cycle's shift.
    always_comb begin
        w_cur_word_post = r_cur_word;
        w_cur_vld_post  = r_cur_vld;
        w_nxt_vld_post  = r_nxt_vld;
        if (i_shift) begin
            w_cur_word_post = r_nxt_word;
            w_cur_vld_post  = r_nxt_vld;
            w_nxt_vld_post  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur_word <= '0;
            r_cur_vld  <= 1'b0;
            r_nxt_word <= '0;
            r_nxt_vld  <= 1'b0;
        end else if (i_clear) begin
            r_cur_vld  <= 1'b0;
            r_nxt_vld  <= 1'b0;
        end else begin
            r_cur_word <= w_cur_word_post;
            r_cur_vld  <= w_cur_vld_post;
            r_nxt_vld  <= w_nxt_vld_post;
            if (i_capture) begin
                if (!w_cur_vld_post) begin
                    r_cur_word <= i_data;
                    r_cur_vld  <= 1'b1;
                end else begin
                    r_nxt_word <= i_data;
                    r_nxt_vld  <= 1'b1;
                end
            end
        end
    end

    assign o_cur_word = r_cur_word;
    assign o_cur_vld  = r_cur_vld;
    assign o_occ      = {1'b0, r_cur_vld} + {1'b0, r_nxt_vld};

endmodule

// File: rtl/bin_pixel_feeder.sv
// Pops 1-bpp words from the pixel FIFO and serves one bit per VGA active pixel, flagging underflow.
// Define BIN_PIXEL_FEEDER_STATS_EN to add the saturating o_underflow_cnt output.
module bin_pixel_feeder import bin_pixel_feeder_pkg::*; #(
    parameter int unsigned WORD_W        = DEFAULT_WORD_W,
    parameter bit          MSB_FIRST     = 1'b1,
    parameter logic        UNDERFLOW_BIT = PIX_WHITE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic              i_pix_req,
    input  logic              i_fifo_empty,
    input  logic [WORD_W-1:0] i_fifo_rdata,
    output logic              o_fifo_rd,
    output logic              o_pix_bit,
    output logic              o_underflow
`ifdef BIN_PIXEL_FEEDER_STATS_EN
    ,
    output logic [15:0]       o_underflow_cnt
`endif
);

    localparam int unsigned     IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_rd_pend;
    logic              r_drop;
    logic              r_underflow;

    logic              w_run;
    logic [WORD_W-1:0] w_cur_word;
    logic              w_cur_vld;
    logic [1:0]        w_occ;
    logic [1:0]        w_inflight;
    logic              w_fifo_rd;
    logic              w_consume;
    logic              w_shift;
    logic              w_capture;
    logic              w_uf_evt;
    logic [IDX_W-1:0]  w_sel_idx;

    bin_word_buf #(
        .WORD_W (WORD_W)
    ) u_word_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (i_frame_start),
        .i_shift    (w_shift),
        .i_capture  (w_capture),
        .i_data     (i_fifo_rdata),
        .o_cur_word (w_cur_word),
        .o_cur_vld  (w_cur_vld),
        .o_occ      (w_occ)
    );

    // Buffered words plus the one in flight never exceed two.
    assign w_run      = (r_state == ST_RUN);
    assign w_inflight = w_occ + {1'b0, r_rd_pend};
    assign w_fifo_rd  = w_run && !i_rst && !i_fifo_empty && !i_frame_start
                        && (w_inflight < 2'd2);

    assign w_consume  = w_run && !i_frame_start && i_pix_req && w_cur_vld;
    assign w_shift    = w_consume && (r_bit_idx == LAST_IDX);
    assign w_capture  = w_run && r_rd_pend && !r_drop;
    assign w_uf_evt   = w_run && !i_frame_start && i_pix_req && !w_cur_vld;

    assign w_sel_idx  = MSB_FIRST ? (LAST_IDX - r_bit_idx) : r_bit_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bit_idx   <= '0;
            r_rd_pend   <= 1'b0;
            r_drop      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_pend <= w_fifo_rd;
            if (i_frame_start) begin
                r_state     <= ST_RUN;
                r_bit_idx   <= '0;
                r_drop      <= r_rd_pend;
                r_underflow <= 1'b0;
            end else begin
                r_drop <= 1'b0;
                if (w_consume) begin
                    r_bit_idx <= w_shift ? '0 : r_bit_idx + IDX_W'(1);
                end
                // A missing pixel is skipped: bit_idx holds, the flag sticks.
                if (w_uf_evt) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

`ifdef BIN_PIXEL_FEEDER_STATS_EN
    logic [15:0] r_uf_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_frame_start) begin
            r_uf_cnt <= '0;
        end else if (w_uf_evt && (r_uf_cnt != 16'hFFFF)) begin
            r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end

    assign o_underflow_cnt = r_uf_cnt;
`else
    // Without the stats option only the sticky flag reports underflow.
`endif

    assign o_fifo_rd   = w_fifo_rd;
    assign o_pix_bit   = w_cur_vld ? w_cur_word[w_sel_idx] : UNDERFLOW_BIT;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_bin_pixel_feeder.sv
// Directed bench for bin_pixel_feeder: vector table for the basic two-word frame, hand-written
// sequences for underflow, mid-word frame_start, reset, LSB-first and a shortened VGA frame.
module tb_bin_pixel_feeder;
    import bin_pixel_feeder_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic         pix_req;
    logic         fifo_empty;
    logic [W-1:0] fifo_rdata = '0;
    logic         fifo_rd;
    logic         pix_bit;
    logic         underflow;

    logic         fs_l;
    logic         pr_l;
    logic         empty_l;
    logic [W-1:0] rdata_l;
    logic         rd_l;
    logic         pix_l;
    logic         uf_l;

`ifdef BIN_PIXEL_FEEDER_STATS_EN
    logic [15:0]  uf_cnt;
    logic [15:0]  uf_cnt_l;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model, normal (non-show-ahead) read timing
    logic [W-1:0] mem [0:63];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    int           rd_count = 0;
    int           rd_empty_err = 0;
    int           gen_base = 0;
    logic         gen_mode = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_count <= rd_count + 1;
            if (fifo_empty) begin
                rd_empty_err <= rd_empty_err + 1;
            end else begin
                if (gen_mode) begin
                    fifo_rdata <= (((rd_ptr - gen_base) % 2) == 0) ? 16'hAAAA : 16'h5555;
                end else begin
                    fifo_rdata <= mem[rd_ptr % 64];
                end
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    bin_pixel_feeder #(
        .WORD_W        (W),
        .MSB_FIRST     (1'b1),
        .UNDERFLOW_BIT (1'b0)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_start (frame_start),
        .i_pix_req     (pix_req),
        .i_fifo_empty  (fifo_empty),
        .i_fifo_rdata  (fifo_rdata),
        .o_fifo_rd     (fifo_rd),
        .o_pix_bit     (pix_bit),
        .o_underflow   (underflow)
`ifdef BIN_PIXEL_FEEDER_STATS_EN
        ,
        .o_underflow_cnt (uf_cnt)
`endif
    );

    bin_pixel_feeder #(
        .WORD_W        (W),
        .MSB_FIRST     (1'b0),
        .UNDERFLOW_BIT (1'b0)
    ) u_dut_lsb (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_start (fs_l),
        .i_pix_req     (pr_l),
        .i_fifo_empty  (empty_l),
        .i_fifo_rdata  (rdata_l),
        .o_fifo_rd     (rd_l),
        .o_pix_bit     (pix_l),
        .o_underflow   (uf_l)
`ifdef BIN_PIXEL_FEEDER_STATS_EN
        ,
        .o_underflow_cnt (uf_cnt_l)
`endif
    );

    typedef struct {
        logic fs;
        logic pr;
        logic exp_pix;
        logic exp_rd;
        logic exp_uf;
    } vec_t;

    vec_t vecs [36];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic cyc(input logic fs, input logic pr);
        @(negedge clk);
        frame_start = fs;
        pix_req     = pr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_start = 1'b0;
        pix_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        chk("rst_pix_bit", pix_bit, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
    endtask

    initial begin
        logic [31:0] seq;
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        logic [W-1:0] ew;
        int base;
        int p;
        int bad;
        logic act;

        rst = 1'b1;
        frame_start = 1'b0;
        pix_req = 1'b0;
        fs_l = 1'b0;
        pr_l = 1'b0;
        empty_l = 1'b1;
        rdata_l = '0;

        // Test 1 table: F00F then 00FF, MSB first
        seq = 32'hF00F00FF;
        for (int i = 0; i < 36; i++) begin
            vecs[i].fs      = (i == 0);
            vecs[i].pr      = (i >= 3 && i < 35);
            vecs[i].exp_rd  = (i == 1 || i == 2);
            vecs[i].exp_pix = (i >= 3 && i < 35) ? seq[31 - (i - 3)] : 1'b0;
            vecs[i].exp_uf  = 1'b0;
        end

        // ---- Test 5: pix_req before frame_start, then rst mid-RUN
        do_reset();
        flush();
        push(16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1);
            chk("idle_fifo_rd", fifo_rd, 1'b0);
            chk("idle_underflow", underflow, 1'b0);
        end
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk("t5_first_rd", fifo_rd, 1'b1);
        chk("t5_uf_pix", pix_bit, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t5_uf_set", underflow, 1'b1);
        cyc(1'b0, 1'b1);
        chk("t5_pix", pix_bit, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        pix_req = 1'b0;
        push(16'h1234);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_rst_fifo_rd", fifo_rd, 1'b0);
        chk("t5_rst_underflow", underflow, 1'b0);
        chk("t5_rst_pix", pix_bit, 1'b0);
`ifdef BIN_PIXEL_FEEDER_STATS_EN
        chk("t5_rst_uf_cnt", uf_cnt, 16'd0);
`endif
        flush();

        // ---- Test 1: two words, 32 pixels
        do_reset();
        flush();
        push(16'hF00F);
        push(16'h00FF);
        base = rd_count;
        for (int i = 0; i < 36; i++) begin
            cyc(vecs[i].fs, vecs[i].pr);
            chk($sformatf("t1_pix[%0d]", i), pix_bit, vecs[i].exp_pix);
            chk($sformatf("t1_rd[%0d]", i), fifo_rd, vecs[i].exp_rd);
            chk($sformatf("t1_uf[%0d]", i), underflow, vecs[i].exp_uf);
        end
        chk("t1_read_count", rd_count - base, 2);

        // ---- Test 3: one word then underflow
        do_reset();
        flush();
        w1 = 16'hC3A5;
        push(w1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t3_rd", fifo_rd, 1'b1);
        cyc(1'b0, 1'b0);
        chk("t3_rd_empty", fifo_rd, 1'b0);
        chk("t3_pix_pre", pix_bit, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b1);
            chk($sformatf("t3_pix[%0d]", k), pix_bit, w1[15 - k]);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1);
            chk($sformatf("t3_uf_pix[%0d]", k), pix_bit, 1'b0);
            if (k == 0) chk("t3_uf_not_yet", underflow, 1'b0);
            if (k == 1) chk("t3_uf_set", underflow, 1'b1);
        end
        cyc(1'b0, 1'b0);
        chk("t3_uf_sticky", underflow, 1'b1);
`ifdef BIN_PIXEL_FEEDER_STATS_EN
        chk("t3_uf_cnt", uf_cnt, 16'd4);
`endif

        // ---- Test 4: frame_start at bit_idx 7 with a read pending
        do_reset();
        flush();
        w1 = 16'hF0F0;
        w2 = 16'h3C5A;
        push(w1);
        push(w2);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t4_rd1", fifo_rd, 1'b1);
        cyc(1'b0, 1'b1);
        chk("t4_uf_pix", pix_bit, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b1);
            chk($sformatf("t4_w1[%0d]", k), pix_bit, w1[15 - k]);
            if (k == 0) chk("t4_uf_set", underflow, 1'b1);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b1);
            chk($sformatf("t4_w2[%0d]", k), pix_bit, w2[15 - k]);
        end
        @(negedge clk);
        push(16'h5FFF);
        push(16'hA000);
        frame_start = 1'b0;
        pix_req = 1'b1;
        #1;
        chk("t4_rd_at_idx6", fifo_rd, 1'b1);
        chk("t4_w2[6]", pix_bit, w2[9]);
        cyc(1'b1, 1'b0);
        chk("t4_fs_rd_forced", fifo_rd, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t4_post_fs_rd", fifo_rd, 1'b1);
        chk("t4_post_fs_pix", pix_bit, 1'b0);
        chk("t4_post_fs_uf", underflow, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t4_empty_rd", fifo_rd, 1'b0);
        w1 = 16'hA000;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1);
            chk($sformatf("t4_next_frame[%0d]", k), pix_bit, w1[15 - k]);
        end
        cyc(1'b0, 1'b0);
        chk("t4_uf_end", underflow, 1'b0);

        // ---- Test 6: LSB-first instance, word 0001
        @(negedge clk);
        fs_l = 1'b1;
        #1;
        chk("t6_fs_rd", rd_l, 1'b0);
        @(negedge clk);
        fs_l = 1'b0;
        empty_l = 1'b0;
        #1;
        chk("t6_rd", rd_l, 1'b1);
        chk("t6_pix_pre", pix_l, 1'b0);
        @(negedge clk);
        empty_l = 1'b1;
        rdata_l = 16'h0001;
        #1;
        chk("t6_rd_empty", rd_l, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            pr_l = 1'b1;
            #1;
            chk($sformatf("t6_pix[%0d]", k), pix_l, (k == 0) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        pr_l = 1'b0;
        #1;
        chk("t6_uf", uf_l, 1'b0);

        // ---- Test 2: shortened VGA frame (2 blank + 10 active lines), alternating AAAA/5555
        do_reset();
        flush();
        gen_base = rd_ptr;
        gen_mode = 1'b1;
        wr_ptr = rd_ptr + 400;
        base = rd_count;
        p = 0;
        bad = 0;
        for (int line = 0; line < 12; line++) begin
            for (int h = 0; h < int'(H_TOTAL); h++) begin
                act = (line >= 2) && (h >= int'(H_SYNC + H_BP)) && (h < int'(H_SYNC + H_BP + H_ACT));
                cyc((line == 0 && h == 0), act);
                if (act) begin
                    ew = (((p / 16) % 2) == 0) ? 16'hAAAA : 16'h5555;
                    if (pix_bit !== ew[15 - (p % 16)]) begin
                        bad++;
                    end
                    p++;
                end
            end
        end
        chk("t2_bad_pixels", bad, 0);
        chk("t2_pixel_count", p, 6400);
        chk("t2_read_count", rd_count - base, 400);
        chk("t2_underflow", underflow, 1'b0);
        cyc(1'b0, 1'b0);
        gen_mode = 1'b0;

        chk("rd_while_empty", rd_empty_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
